aes_encrypt: RTL and testbench

- Iterative AES-128 encryption core; the encrypt-direction counterpart of the team's AES decryption core.
- Takes a 128-bit key and plaintext and produces ciphertext using the same level START / DONE handshake as the decryption core.
- Round keys are generated on the fly, one per round; there is no stored key schedule.
- S-box lookups use combinational instances of a byte S-box submodule (aes_sbox: 8-bit in, 8-bit out): 16 for state bytes, 4 for SubWord.

---
 rtl/aes_encrypt.sv | 207 ++++++++++++++++++++
 tb/tb_aes_encrypt.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt.sv
// aes_sbox: AES forward S-box, one byte in, one byte out.
// Latency: purely combinational, no registers.
// Backpressure: none, the output follows the input.
module aes_sbox (
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    // Entry for input x lives at bits [(255-x)*8 +: 8]; 255-x equals ~x for a byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_lo;

    assign bit_lo   = {~sbox_in, 3'b000};
    assign sbox_out = SBOX[bit_lo +: 8];

endmodule

// aes_encrypt: iterative AES-128 encryption, round keys expanded on the fly.
// Latency: AES_DONE rises 67 edges after AES_START is sampled high in WAIT.
// Backpressure: level handshake; DONE is held until AES_START drops.
module aes_encrypt (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         AES_START,
    output logic         AES_DONE,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_DEC,
    output logic [127:0] AES_MSG_ENC
);

    typedef enum logic [3:0] {
        ST_WAIT  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_SUB   = 4'd2,
        ST_SHIFT = 4'd3,
        ST_MIX0  = 4'd4,
        ST_MIX1  = 4'd5,
        ST_MIX2  = 4'd6,
        ST_MIX3  = 4'd7,
        ST_ADDRK = 4'd8,
        ST_DONE  = 4'd9
    } fsm_t;

    fsm_t         fsm_state;
    fsm_t         fsm_next;
    logic [127:0] state;
    logic [127:0] rk;
    logic [3:0]   round;

    logic [127:0] sub_bytes;
    logic [127:0] shift_rows;
    logic [127:0] mix_cols;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_word;
    logic [31:0]  w0_nxt;
    logic [31:0]  w1_nxt;
    logic [31:0]  w2_nxt;
    logic [31:0]  w3_nxt;
    logic         last_round;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Byte s(r,c) sits at bits [127-8*(4c+r) -: 8].
    for (genvar i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (
            .sbox_in  (state[127-8*i -: 8]),
            .sbox_out (sub_bytes[127-8*i -: 8])
        );
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shift_rows[127-8*(4*c+r) -: 8] = state[127-8*(4*((c+r)%4)+r) -: 8];
        end
        assign mix_cols[127-32*c -: 32] = mix_col(state[127-32*c -: 32]);
    end

    assign rot_w3 = {rk[23:0], rk[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_subword
        aes_sbox u_sbox (
            .sbox_in  (rot_w3[31-8*j -: 8]),
            .sbox_out (sub_word[31-8*j -: 8])
        );
    end

    assign w0_nxt     = rk[127:96] ^ sub_word ^ {rcon(round), 24'h000000};
    assign w1_nxt     = rk[95:64] ^ w0_nxt;
    assign w2_nxt     = rk[63:32] ^ w1_nxt;
    assign w3_nxt     = rk[31:0] ^ w2_nxt;
    assign last_round = (round == 4'd10);
    assign AES_DONE   = (fsm_state == ST_DONE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fsm_state <= ST_WAIT;
        end else begin
            fsm_state <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm_state;
        case (fsm_state)
            ST_WAIT:  if (AES_START) fsm_next = ST_LOAD;
            ST_LOAD:  fsm_next = ST_SUB;
            ST_SUB:   fsm_next = ST_SHIFT;
            ST_SHIFT: fsm_next = last_round ? ST_ADDRK : ST_MIX0;
            ST_MIX0:  fsm_next = ST_MIX1;
            ST_MIX1:  fsm_next = ST_MIX2;
            ST_MIX2:  fsm_next = ST_MIX3;
            ST_MIX3:  fsm_next = ST_ADDRK;
            ST_ADDRK: fsm_next = last_round ? ST_DONE : ST_SUB;
            ST_DONE:  if (!AES_START) fsm_next = ST_WAIT;
            default:  fsm_next = ST_WAIT;
        endcase
    end

    // One MixColumns column per cycle keeps only a single column's worth of writes live.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= '0;
            rk          <= '0;
            round       <= '0;
            AES_MSG_ENC <= '0;
        end else begin
            case (fsm_state)
                ST_LOAD: begin
                    state <= AES_MSG_DEC ^ AES_KEY;
                    rk    <= AES_KEY;
                    round <= 4'd1;
                end
                ST_SUB: begin
                    state <= sub_bytes;
                    rk    <= {w0_nxt, w1_nxt, w2_nxt, w3_nxt};
                end
                ST_SHIFT: state          <= shift_rows;
                ST_MIX0:  state[127:96]  <= mix_cols[127:96];
                ST_MIX1:  state[95:64]   <= mix_cols[95:64];
                ST_MIX2:  state[63:32]   <= mix_cols[63:32];
                ST_MIX3:  state[31:0]    <= mix_cols[31:0];
                ST_ADDRK: begin
                    state <= state ^ rk;
                    if (last_round) begin
                        AES_MSG_ENC <= state ^ rk;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt.sv
// Self-checking bench for aes_encrypt: FIPS-197 vectors, random vectors against a
// table-free AES model, and handshake / reset / input-stability sequences.
module tb_aes_encrypt;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         AES_START;
    logic         AES_DONE;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_DEC;
    logic [127:0] AES_MSG_ENC;

    int checks = 0;
    int errors = 0;

    aes_encrypt dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .AES_START   (AES_START),
        .AES_DONE    (AES_DONE),
        .AES_KEY     (AES_KEY),
        .AES_MSG_DEC (AES_MSG_DEC),
        .AES_MSG_ENC (AES_MSG_ENC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] sbox_tab [256];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: GF(2^8) arithmetic, no lookup constants
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   st  [4][4];
        logic [7:0]   tmp [4][4];
        logic [31:0]  w   [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    tmp[r][c] = sbox_tab[st[r][(c+r)%4]];
            st = tmp;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[0][c]; a1 = st[1][c]; a2 = st[2][c]; a3 = st[3][c];
                    st[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    st[r][c] = st[r][c] ^ w[4*rnd+c][31-8*r -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                out[127-8*(4*c+r) -: 8] = st[r][c];
        return out;
    endfunction

    // mode 0: hold START, release in DONE; 1: hold START, stay in DONE; 2: one-cycle START pulse
    task automatic run_op(input logic [127:0] key, input logic [127:0] pt,
                          input logic [127:0] hold_val, input bit check_hold, input int mode,
                          output logic [127:0] ct, output int lat, output int hold_err);
        @(negedge CLK);
        AES_KEY     = key;
        AES_MSG_DEC = pt;
        AES_START   = 1'b1;
        @(posedge CLK);
        lat      = 0;
        hold_err = 0;
        if (mode == 2) begin
            @(negedge CLK);
            AES_START = 1'b0;
            @(posedge CLK);
            #1;
            lat = 1;
        end
        while (!AES_DONE && lat < 200) begin
            if (check_hold && AES_MSG_ENC !== hold_val) hold_err++;
            @(posedge CLK);
            #1;
            lat++;
        end
        ct = AES_MSG_ENC;
        if (mode == 0) begin
            @(negedge CLK);
            AES_START = 1'b0;
            @(posedge CLK);
            #1;
            chk("done_falls_after_start_drop", 128'(AES_DONE), 128'd0);
        end else if (mode == 2) begin
            @(posedge CLK);
            #1;
            chk("pulse_done_one_cycle", 128'(AES_DONE), 128'd0);
        end
    endtask

    logic [127:0] ct;
    logic [127:0] prev_ct;
    int           lat;
    int           hold_err;
    int           bad;

    initial begin
        RESET_N     = 1'b0;
        AES_START   = 1'b0;
        AES_KEY     = '0;
        AES_MSG_DEC = '0;
        build_sbox();

        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        for (int i = 2; i < 8; i++) begin
            vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].ct  = aes_ref(vecs[i].key, vecs[i].pt);
        end

        #23;
        chk("reset_done", 128'(AES_DONE), 128'd0);
        chk("reset_enc", AES_MSG_ENC, 128'd0);
        chk("reset_rk", dut.rk, 128'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Back-to-back runs; each must hold the previous ciphertext until its own finish.
        prev_ct = '0;
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].key, vecs[i].pt, prev_ct, 1'b1, 0, ct, lat, hold_err);
            chk($sformatf("vec%0d_ct", i), ct, vecs[i].ct);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd67);
            chk($sformatf("vec%0d_hold_prev", i), 128'(hold_err), 128'd0);
            if (i == 1) chk("c1_round10_key", dut.rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
            prev_ct = vecs[i].ct;
        end

        // START held high long after completion: one result, DONE stays up.
        run_op(vecs[0].key, vecs[0].pt, prev_ct, 1'b0, 1, ct, lat, hold_err);
        chk("hold_ct", ct, vecs[0].ct);
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge CLK);
            #1;
            if (!AES_DONE || AES_MSG_ENC !== vecs[0].ct) bad++;
        end
        chk("hold_done_stays", 128'(bad), 128'd0);
        @(negedge CLK);
        AES_START = 1'b0;
        @(posedge CLK);
        #1;
        chk("hold_release_to_wait", 128'(AES_DONE), 128'd0);
        @(posedge CLK);
        #1;
        chk("wait_idle_start_low", 128'(AES_DONE), 128'd0);

        run_op(vecs[1].key, vecs[1].pt, vecs[0].ct, 1'b1, 2, ct, lat, hold_err);
        chk("pulse_ct", ct, vecs[1].ct);
        chk("pulse_latency", 128'(lat), 128'd67);

        // Inputs scrambled after capture must not disturb the run.
        @(negedge CLK);
        AES_KEY     = vecs[2].key;
        AES_MSG_DEC = vecs[2].pt;
        AES_START   = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        AES_KEY     = '1;
        AES_MSG_DEC = '1;
        lat = 0;
        while (!AES_DONE && lat < 200) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        chk("input_stability_ct", AES_MSG_ENC, vecs[2].ct);
        @(negedge CLK);
        AES_START = 1'b0;
        @(posedge CLK);

        // Asynchronous reset mid-run.
        @(negedge CLK);
        AES_KEY     = vecs[1].key;
        AES_MSG_DEC = vecs[1].pt;
        AES_START   = 1'b1;
        @(posedge CLK);
        repeat (30) @(posedge CLK);
        #3;
        RESET_N = 1'b0;
        #1;
        chk("midrun_reset_done", 128'(AES_DONE), 128'd0);
        chk("midrun_reset_enc", AES_MSG_ENC, 128'd0);
        AES_START = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge CLK);
            #1;
            if (AES_DONE || AES_MSG_ENC !== 128'd0) bad++;
        end
        chk("post_reset_stays_wait", 128'(bad), 128'd0);
        run_op(vecs[1].key, vecs[1].pt, 128'd0, 1'b1, 0, ct, lat, hold_err);
        chk("post_reset_c1_ct", ct, vecs[1].ct);
        chk("post_reset_c1_latency", 128'(lat), 128'd67);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
